mem_access_unit: RTL and testbench

Sequential load/store unit between the execute stage and a request/grant data-memory bus. Accepts one access per handshake, generates the aligned bus address, byte write mask and lane-shifted store data, waits for the bus, then returns sign- or zero-extended load data. Parametrised successor of the single-cycle combinational memory stage. Adds data-width generality, handshakes, multi-cycle latency and error reporting.

---
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Sequential load/store unit: one request/grant bus access per request, with byte-lane
// alignment and load extension. Define MAU_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module mem_access_unit #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_we,
   input  logic [1:0]          in_size,
   input  logic                in_unsigned,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [XLEN-1:0]     in_wdata,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_rdata,
   output logic                out_err,
   output logic                mem_req,
   input  logic                mem_gnt,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_wmask,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata,
   input  logic                mem_err
);

   localparam int NBYTES = XLEN / 8;
   localparam int OFF_W  = $clog2(NBYTES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

   state_t              state;
   logic                lat_we;
   logic [1:0]          lat_size;
   logic                lat_uns;
   logic [OFF_W-1:0]    lat_off;

   logic [OFF_W-1:0]    addr_lo;
   logic [OFF_W-1:0]    size_mask;
   logic [OFF_W-1:0]    req_off;
   logic                size_bad;
   logic                req_fault;
   logic [XLEN-1:0]     wdata_lane;
   logic [XLEN-1:0]     rd_shifted;
   logic [XLEN-1:0]     rd_ext;

   function automatic logic [NBYTES-1:0] store_mask(input logic [1:0] size,
                                                    input logic [OFF_W-1:0] off);
      logic [15:0]        ones;
      logic [NBYTES-1:0]  m;
      ones = (16'd1 << (5'd1 << size)) - 16'd1;
      m    = ones[NBYTES-1:0];
      return m << off;
   endfunction

   // Extension works by parking the access's top bit at the word MSB, then
   // shifting back (arithmetic for signed loads, logical for unsigned loads).
   function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                   input logic [1:0] size,
                                                   input logic uns);
      int                      nbits;
      int                      sh;
      logic signed [XLEN-1:0]  left;
      nbits = 8 << size;
      if (nbits >= XLEN) return d;
      sh   = XLEN - nbits;
      left = d << sh;
      if (uns) return unsigned'(left) >> sh;
      return left >>> sh;
   endfunction

   always_comb begin
      addr_lo   = in_addr[OFF_W-1:0];
      size_mask = OFF_W'((4'd1 << in_size) - 4'd1);
      size_bad  = (XLEN == 32) && (in_size == 2'd3);
`ifdef MAU_MISALIGN_TRAP_EN
      req_off   = addr_lo;
      req_fault = size_bad | (|(addr_lo & size_mask));
`else
      req_off   = addr_lo & ~size_mask;
      req_fault = size_bad;
`endif
   end

   assign wdata_lane = in_wdata << {req_off, 3'b000};
   assign rd_shifted = mem_rdata >> {lat_off, 3'b000};
   assign rd_ext     = extend_load(rd_shifted, lat_size, lat_uns);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_rdata <= '0;
         out_err   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         lat_we    <= 1'b0;
         lat_size  <= '0;
         lat_uns   <= 1'b0;
         lat_off   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  lat_we   <= in_we;
                  lat_size <= in_size;
                  lat_uns  <= in_unsigned;
                  lat_off  <= req_off;
                  in_ready <= 1'b0;
                  if (req_fault) begin
                     state     <= RESP;
                     out_valid <= 1'b1;
                     out_err   <= 1'b1;
                     out_rdata <= '0;
                  end else begin
                     state     <= REQ;
                     mem_req   <= 1'b1;
                     mem_we    <= in_we;
                     mem_addr  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     mem_wdata <= in_we ? wdata_lane : '0;
                     mem_wmask <= in_we ? store_mask(in_size, req_off) : '0;
                  end
               end
            end
            // Bus fields stay registered and untouched until the grant.
            REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  if (lat_we) begin
                     state     <= RESP;
                     out_valid <= 1'b1;
                     out_err   <= mem_err;
                     out_rdata <= '0;
                  end else begin
                     state <= WAIT_R;
                  end
               end
            end
            WAIT_R: begin
               if (mem_rvalid) begin
                  state     <= RESP;
                  out_valid <= 1'b1;
                  out_err   <= mem_err;
                  out_rdata <= mem_err ? '0 : rd_ext;
               end
            end
            RESP: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_err   <= 1'b0;
                  out_rdata <= '0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN = 64): expected responses are queued at issue
// and popped by a monitor whenever a response handshake is presented.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_we = 1'b0;
   logic [1:0]  in_size = '0;
   logic        in_unsigned = 1'b0;
   logic [63:0] in_addr = '0;
   logic [63:0] in_wdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_rdata;
   logic        out_err;
   logic        mem_req;
   logic        mem_gnt = 1'b0;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic        mem_err = 1'b0;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [64:0] sb[$];
   logic [64:0] mon_exp;

   mem_access_unit #(.XLEN(64), .ADDR_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_size(in_size),
      .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_resp: got rdata 0x%0h err %0b, expected no response", out_rdata, out_err);
         end else begin
            mon_exp = sb.pop_front();
            check("resp_rdata", out_rdata, mon_exp[63:0]);
            check("resp_err", {63'd0, out_err}, {63'd0, mon_exp[64]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: in_ready 0, expected 1");
      end
      in_valid = 1'b1; in_we = we; in_size = size; in_unsigned = uns;
      in_addr = addr; in_wdata = wdata;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] rdata, input logic rerr,
                          input logic [63:0] exp_addr, input logic [63:0] exp_rdata,
                          input logic exp_err, input int hold);
      issue(1'b0, size, uns, addr, 64'h0);
      sb.push_back({exp_err, exp_rdata});
      check({tag, "_req"}, {63'd0, mem_req}, 64'd1);
      check({tag, "_we"}, {63'd0, mem_we}, 64'd0);
      check({tag, "_addr"}, mem_addr, exp_addr);
      check({tag, "_wmask"}, {56'd0, mem_wmask}, 64'd0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check({tag, "_req_drop"}, {63'd0, mem_req}, 64'd0);
      check({tag, "_early"}, {63'd0, out_valid}, 64'd0);
      if (hold > 0) out_ready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = rerr;
      tick();
      mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      check({tag, "_latency"}, {63'd0, out_valid}, 64'd1);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
         check({tag, "_hold_rdata"}, out_rdata, exp_rdata);
         check({tag, "_hold_err"}, {63'd0, out_err}, {63'd0, exp_err});
         check({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      tick();
      check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
      check({tag, "_valid_clr"}, {63'd0, out_valid}, 64'd0);
   endtask

   task automatic do_store(input string tag, input logic [1:0] size, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] exp_addr,
                           input logic [7:0] exp_mask, input logic [63:0] exp_wdata,
                           input int gdelay, input logic gerr);
      issue(1'b1, size, 1'b0, addr, wdata);
      sb.push_back({gerr, 64'h0});
      check({tag, "_we"}, {63'd0, mem_we}, 64'd1);
      for (int i = 0; i <= gdelay; i++) begin
         if (i > 0) tick();
         check({tag, "_req"}, {63'd0, mem_req}, 64'd1);
         check({tag, "_addr"}, mem_addr, exp_addr);
         check({tag, "_wmask"}, {56'd0, mem_wmask}, {56'd0, exp_mask});
         check({tag, "_wdata"}, mem_wdata, exp_wdata);
      end
      mem_gnt = 1'b1; mem_err = gerr;
      tick();
      mem_gnt = 1'b0; mem_err = 1'b0;
      check({tag, "_latency"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_req_drop"}, {63'd0, mem_req}, 64'd0);
      tick();
      check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_mem_req", {63'd0, mem_req}, 64'd0);
      check("rst_out_err", {63'd0, out_err}, 64'd0);
      check("rst_wmask", {56'd0, mem_wmask}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      do_load("lb_s", 2'd0, 1'b0, 64'h8000_0005, 64'h0011_8000_0000_0000, 1'b0,
              64'h8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 0);
      do_load("lb_u", 2'd0, 1'b1, 64'h8000_0005, 64'h0011_8000_0000_0000, 1'b0,
              64'h8000_0000, 64'h0000_0000_0000_0080, 1'b0, 0);
      do_store("sh", 2'd1, 64'h8000_1006, 64'h0000_0000_0000_ABCD, 64'h8000_1000,
               8'hC0, 64'hABCD_0000_0000_0000, 3, 1'b0);
      do_store("sb_err", 2'd0, 64'h8000_1003, 64'h0000_0000_0000_005A, 64'h8000_1000,
               8'h08, 64'h0000_0000_5A00_0000, 0, 1'b1);
      do_load("lw_s", 2'd2, 1'b0, 64'h8000_2004, 64'h8765_4321_DEAD_BEEF, 1'b0,
              64'h8000_2000, 64'hFFFF_FFFF_8765_4321, 1'b0, 0);
      do_load("lw_u", 2'd2, 1'b1, 64'h8000_2004, 64'h8765_4321_DEAD_BEEF, 1'b0,
              64'h8000_2000, 64'h0000_0000_8765_4321, 1'b0, 0);
      do_load("ld_err", 2'd3, 1'b0, 64'h8000_2008, 64'h1234_5678_9ABC_DEF0, 1'b1,
              64'h8000_2008, 64'h0, 1'b1, 2);
      do_load("ld_ok", 2'd3, 1'b0, 64'h8000_2008, 64'hF234_5678_9ABC_DEF0, 1'b0,
              64'h8000_2008, 64'hF234_5678_9ABC_DEF0, 1'b0, 0);

`ifdef MAU_MISALIGN_TRAP_EN
      issue(1'b0, 2'd2, 1'b0, 64'h8000_3002, 64'h0);
      sb.push_back({1'b1, 64'h0});
      check("mis_no_req", {63'd0, mem_req}, 64'd0);
      check("mis_valid", {63'd0, out_valid}, 64'd1);
      check("mis_err", {63'd0, out_err}, 64'd1);
      tick();
      check("mis_idle", {63'd0, in_ready}, 64'd1);
`else
      do_load("mis_align", 2'd2, 1'b0, 64'h8000_3002, 64'h1111_2222_8000_0001, 1'b0,
              64'h8000_3000, 64'hFFFF_FFFF_8000_0001, 1'b0, 0);
`endif

      issue(1'b0, 2'd2, 1'b0, 64'h8000_4000, 64'h0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      check("abort_in_ready", {63'd0, in_ready}, 64'd1);
      check("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check("abort_mem_req", {63'd0, mem_req}, 64'd0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
      tick();
      mem_rvalid = 1'b0;
      check("abort_no_resp0", {63'd0, out_valid}, 64'd0);
      tick();
      check("abort_no_resp1", {63'd0, out_valid}, 64'd0);
      check("abort_still_idle", {63'd0, in_ready}, 64'd1);

      do_load("post_rst", 2'd1, 1'b0, 64'h8000_5002, 64'h0000_0000_7FFF_0000, 1'b0,
              64'h8000_5000, 64'h0000_0000_0000_7FFF, 1'b0, 0);

      tick();
      tick();
      check("sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
